// File: rtl/line_point_counter_if.sv
// Host-side bundle for line_point_counter: table writes, scan control and result.
// master = host that loads the table and starts scans; slave = the counter.
interface line_point_counter_if #(
  parameter int DW = 8,
  parameter int AW = 4,
  parameter int CW = 8
);
  logic          start;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] coef_a;
  logic [DW-1:0] coef_c;
  logic          busy;
  logic          done;
  logic [CW-1:0] result;
  logic          overflow;

  modport master (
    output start, wr_en, wr_addr, wr_data, coef_a, coef_c,
    input  busy, done, result, overflow
  );

  modport slave (
    input  start, wr_en, wr_addr, wr_data, coef_a, coef_c,
    output busy, done, result, overflow
  );
endinterface

// File: rtl/line_point_counter.sv
// Scans a table of (x, y) word pairs and counts those on the line (A*x + y) mod 2^DW == C.
// The count is published with a done pulse once the host releases start.
module line_point_counter #(
  parameter int DW = 8,
  parameter int AW = 4,
  parameter int CW = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  line_point_counter_if.slave bus
);
  localparam int            WORDS    = 1 << AW;
  localparam logic [AW-1:0] LAST_PTR = {AW{1'b1}};
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  typedef enum logic [2:0] {IDLE, LOAD_X, LOAD_Y, CALC, ACC, HOLD} state_t;

  state_t        state_reg, state_next;
  logic [DW-1:0] a_reg, a_next;
  logic [DW-1:0] c_reg, c_next;
  logic [DW-1:0] x_reg, x_next;
  logic [DW-1:0] y_reg, y_next;
  logic [DW-1:0] acc_reg, acc_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [CW-1:0] result_reg, result_next;
  logic [AW-1:0] ptr_reg, ptr_next;
  logic          sat_reg, sat_next;
  logic          overflow_reg, overflow_next;
  logic          done_reg, done_next;

  logic [DW-1:0] table_reg [WORDS];
  logic [DW-1:0] rd_word;
  logic          wr_ok;

  // The table is frozen for the whole scan, including HOLD.
  assign wr_ok   = bus.wr_en && (state_reg == IDLE);
  assign rd_word = table_reg[ptr_reg];

  generate
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          table_reg[gi] <= '0;
        end else if (wr_ok && (bus.wr_addr == AW'(gi))) begin
          table_reg[gi] <= bus.wr_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      a_reg        <= '0;
      c_reg        <= '0;
      x_reg        <= '0;
      y_reg        <= '0;
      acc_reg      <= '0;
      cnt_reg      <= '0;
      result_reg   <= '0;
      ptr_reg      <= '0;
      sat_reg      <= 1'b0;
      overflow_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      a_reg        <= a_next;
      c_reg        <= c_next;
      x_reg        <= x_next;
      y_reg        <= y_next;
      acc_reg      <= acc_next;
      cnt_reg      <= cnt_next;
      result_reg   <= result_next;
      ptr_reg      <= ptr_next;
      sat_reg      <= sat_next;
      overflow_reg <= overflow_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    a_next        = a_reg;
    c_next        = c_reg;
    x_next        = x_reg;
    y_next        = y_reg;
    acc_next      = acc_reg;
    cnt_next      = cnt_reg;
    result_next   = result_reg;
    ptr_next      = ptr_reg;
    sat_next      = sat_reg;
    overflow_next = overflow_reg;
    done_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          a_next     = bus.coef_a;
          c_next     = bus.coef_c;
          ptr_next   = '0;
          cnt_next   = '0;
          sat_next   = 1'b0;
          state_next = LOAD_X;
        end
      end
      LOAD_X: begin
        x_next     = rd_word;
        ptr_next   = ptr_reg + AW'(1);
        state_next = LOAD_Y;
      end
      LOAD_Y: begin
        y_next     = rd_word;
        acc_next   = a_reg * x_reg;
        state_next = CALC;
      end
      CALC: begin
        acc_next   = acc_reg + y_reg;
        state_next = ACC;
      end
      ACC: begin
        if (acc_reg == c_reg) begin
          if (cnt_reg == CNT_MAX) begin
            sat_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
        // ptr sits on the y word here, so the last y word ends the scan.
        if (ptr_reg == LAST_PTR) begin
          state_next = HOLD;
        end else begin
          ptr_next   = ptr_reg + AW'(1);
          state_next = LOAD_X;
        end
      end
      HOLD: begin
        if (!bus.start) begin
          result_next   = cnt_reg;
          overflow_next = sat_reg;
          done_next     = 1'b1;
          state_next    = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.busy     = (state_reg != IDLE);
  assign bus.done     = done_reg;
  assign bus.result   = result_reg;
  assign bus.overflow = overflow_reg;
endmodule

// File: tb/tb_line_point_counter.sv
// Randomised bench for line_point_counter: a CW=8 and a CW=2 instance share stimulus and
// are compared every cycle against a pair-counting model, plus literal expectations.
`timescale 1ns/1ps
module tb_line_point_counter;
  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  line_point_counter_if #(.DW(8), .AW(4), .CW(8)) bus8 ();
  line_point_counter_if #(.DW(8), .AW(4), .CW(2)) bus2 ();

  assign bus2.start   = bus8.start;
  assign bus2.wr_en   = bus8.wr_en;
  assign bus2.wr_addr = bus8.wr_addr;
  assign bus2.wr_data = bus8.wr_data;
  assign bus2.coef_a  = bus8.coef_a;
  assign bus2.coef_c  = bus8.coef_c;

  line_point_counter #(.DW(8), .AW(4), .CW(8)) dut8 (
    .clock(clock), .reset_n(reset_n), .bus(bus8.slave));
  line_point_counter #(.DW(8), .AW(4), .CW(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .bus(bus2.slave));

  // ---------------- reference model ----------------
  logic [7:0] m_table [16];
  int m_left = 0;     // scan cycles still to run before HOLD
  bit m_hold = 1'b0;
  int m_cnt  = 0;     // raw match count of the running scan
  int m_res8 = 0, m_ovf8 = 0, m_res2 = 0, m_ovf2 = 0;
  bit m_done = 1'b0;

  function automatic int model_count(input logic [7:0] a, input logic [7:0] c,
                                     input logic we, input logic [3:0] wa,
                                     input logic [7:0] wd);
    int n = 0;
    int xv, yv;
    for (int i = 0; i < 8; i++) begin
      xv = (we && wa == 4'(2*i))   ? int'(wd) : int'(m_table[2*i]);
      yv = (we && wa == 4'(2*i+1)) ? int'(wd) : int'(m_table[2*i+1]);
      if (((int'(a) * xv + yv) % 256) == int'(c)) n++;
    end
    return n;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) m_table[i] <= 8'd0;
      m_left <= 0; m_hold <= 1'b0; m_cnt <= 0; m_done <= 1'b0;
      m_res8 <= 0; m_ovf8 <= 0; m_res2 <= 0; m_ovf2 <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_left == 0 && !m_hold) begin
        if (bus8.wr_en) m_table[bus8.wr_addr] <= bus8.wr_data;
        if (bus8.start) begin
          m_cnt  <= model_count(bus8.coef_a, bus8.coef_c, bus8.wr_en, bus8.wr_addr, bus8.wr_data);
          m_left <= 32;
        end
      end else if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) m_hold <= 1'b1;
      end else if (!bus8.start) begin
        m_hold <= 1'b0;
        m_done <= 1'b1;
        m_res8 <= (m_cnt > 255) ? 255 : m_cnt;
        m_ovf8 <= int'(m_cnt >= 256);
        m_res2 <= (m_cnt > 3) ? 3 : m_cnt;
        m_ovf2 <= int'(m_cnt >= 4);
      end
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;
  bit stop_cmp = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    while (!stop_cmp) begin
      @(negedge clock);
      check("busy",      int'(bus8.busy),     int'(m_left > 0 || m_hold));
      check("done",      int'(bus8.done),     int'(m_done));
      check("result",    int'(bus8.result),   m_res8);
      check("overflow",  int'(bus8.overflow), m_ovf8);
      check("busy_cw2",  int'(bus2.busy),     int'(m_left > 0 || m_hold));
      check("done_cw2",  int'(bus2.done),     int'(m_done));
      check("result_cw2",   int'(bus2.result),   m_res2);
      check("overflow_cw2", int'(bus2.overflow), m_ovf2);
    end
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] legacy [16] = '{8'd1, 8'd255, 8'd0, 8'd0, 8'd0, 8'd2, 8'd0, 8'd0,
                              8'd0, 8'd2, 8'd255, 8'd5, 8'd0, 8'd2, 8'd0, 8'd2};

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_word(input logic [3:0] addr, input logic [7:0] data);
    bus8.wr_en   = 1'b1;
    bus8.wr_addr = addr;
    bus8.wr_data = data;
    tick();
    bus8.wr_en   = 1'b0;
  endtask

  task automatic run_scan(input logic [7:0] a, input logic [7:0] c, input int start_len,
                          input bit mess, input bit wr_with_start);
    bit got = 1'b0;
    bus8.coef_a = a;
    bus8.coef_c = c;
    bus8.start  = 1'b1;
    if (wr_with_start) begin
      bus8.wr_en   = 1'b1;
      bus8.wr_addr = 4'($urandom_range(0, 15));
      bus8.wr_data = 8'($urandom_range(0, 3));
    end
    for (int i = 0; i < start_len + 200 && !got; i++) begin
      tick();
      if (i + 1 >= start_len) bus8.start = 1'b0;
      bus8.wr_en = 1'b0;
      if (mess) begin
        bus8.coef_a  = 8'($urandom);
        bus8.coef_c  = 8'($urandom);
        bus8.wr_en   = 1'($urandom_range(0, 1));
        bus8.wr_addr = 4'($urandom_range(0, 15));
        bus8.wr_data = 8'd9;
      end
      if (bus8.done) got = 1'b1;
    end
    bus8.wr_en = 1'b0;
    bus8.start = 1'b0;
    if (!got) check("done_timeout", 0, 1);
    $display("scan a=%0d c=%0d start_len=%0d result=%0d overflow=%0d result_cw2=%0d overflow_cw2=%0d",
             a, c, start_len, bus8.result, bus8.overflow, bus2.result, bus2.overflow);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus8.start = 1'b0; bus8.wr_en = 1'b0; bus8.wr_addr = '0; bus8.wr_data = '0;
    bus8.coef_a = '0; bus8.coef_c = '0;
    fork
      compare_loop();
    join_none
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    check("reset_result", int'(bus8.result), 0);

    // Legacy table: six pairs lie on 3x+y = 2 (mod 256)
    for (int i = 0; i < 16; i++) write_word(4'(i), legacy[i]);
    run_scan(8'd3, 8'd2, 1, 1'b0, 1'b0);
    check("legacy_result", int'(bus8.result), 6);
    check("legacy_overflow", int'(bus8.overflow), 0);

    // start held for 50 cycles: done only after release
    run_scan(8'd3, 8'd2, 50, 1'b0, 1'b0);
    check("hold_result", int'(bus8.result), 6);

    // Saturation on the CW=2 instance
    for (int i = 0; i < 8; i++) begin
      write_word(4'(2*i), 8'd0);
      write_word(4'(2*i+1), 8'd7);
    end
    run_scan(8'd1, 8'd7, 1, 1'b0, 1'b0);
    check("sat_result_cw2", int'(bus2.result), 3);
    check("sat_overflow_cw2", int'(bus2.overflow), 1);
    check("sat_result_cw8", int'(bus8.result), 8);
    run_scan(8'd1, 8'd0, 1, 1'b0, 1'b0);
    check("rerun_result_cw2", int'(bus2.result), 0);
    check("rerun_overflow_cw2", int'(bus2.overflow), 0);

    // Writes and coefficient changes during a scan have no effect
    for (int i = 0; i < 16; i++) write_word(4'(i), legacy[i]);
    run_scan(8'd3, 8'd2, 5, 1'b1, 1'b0);
    check("blocked_write_result", int'(bus8.result), 6);
    write_word(4'd0, 8'd9);
    run_scan(8'd3, 8'd2, 1, 1'b0, 1'b0);
    check("landed_write_result", int'(bus8.result), 5);

    // Reset in the middle of a scan
    bus8.coef_a = 8'd3; bus8.coef_c = 8'd2; bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    repeat (10) tick();
    #1 reset_n = 1'b0;
    #1;
    check("rst_busy", int'(bus8.busy), 0);
    check("rst_done", int'(bus8.done), 0);
    check("rst_result", int'(bus8.result), 0);
    check("rst_overflow", int'(bus8.overflow), 0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    run_scan(8'd3, 8'd0, 1, 1'b0, 1'b0);
    check("cleared_result", int'(bus8.result), 8);
    check("cleared_result_cw2", int'(bus2.result), 3);
    check("cleared_overflow_cw2", int'(bus2.overflow), 1);

    // Randomised traffic, model-checked every cycle
    for (int it = 0; it < 30; it++) begin
      repeat ($urandom_range(0, 8)) begin
        if ($urandom_range(0, 3) == 0) write_word(4'($urandom_range(0, 15)), 8'($urandom));
        else                           write_word(4'($urandom_range(0, 15)), 8'($urandom_range(0, 3)));
      end
      repeat ($urandom_range(0, 2)) tick();
      run_scan(8'($urandom_range(0, 3)), 8'($urandom_range(0, 5)), int'($urandom_range(1, 40)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (2) tick();
    stop_cmp = 1'b1;
    @(negedge clock);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/line_point_counter.md
Name: line_point_counter

Overview:
- Parametrised successor to the fixed-table "points on a line" scanner.
- Holds a writable table of (x, y) word pairs and scans it on request.
- Counts pairs satisfying (A·x + y) mod 2^DW == C, where slope A and target C are run-time inputs.
- Publishes the count with a done strobe, a saturation flag and a start-release handshake; sits beside a host that loads the table and polls or interrupts on done.

Parameters:
- DW, 8, data width of table words, coefficients and the line arithmetic.
- AW, 4, table address width; table holds 2^AW words = 2^(AW-1) pairs (AW ≥ 1).
- CW, 8, width of the match counter and result.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  level request; sampled in IDLE and HOLD.
- wr_en  input  1  table write strobe.
- wr_addr  input  AW  table write address.
- wr_data  input  DW  table write data.
- coef_a  input  DW  slope A; captured when a scan starts.
- coef_c  input  DW  target C; captured when a scan starts.
- busy  output  1  high from the first scan cycle through HOLD.
- done  output  1  one-cycle pulse when result updates.
- result  output  CW  last published count.
- overflow  output  1  result saturated on the last published scan.

Behaviour:
- Reset (async assert, sync release):
  - All table words, A/C registers, x, y, acc, cnt, ptr, result = 0.
  - overflow = 0, done = 0, busy = 0, state = IDLE.
  - Reset mid-scan aborts the scan with no publish and clears the table.
- Table writes:
  - Write lands at the edge when wr_en=1 and busy=0.
  - Writes with busy=1 are ignored; table is unchanged.
  - Word 2i is x of pair i; word 2i+1 is y of pair i.
- States: IDLE, LOAD_X, LOAD_Y, CALC, ACC, HOLD.
- IDLE:
  - busy=0.
  - If start=1: capture A and C, ptr=0, cnt=0, sat=0, go to LOAD_X.
  - A write in the same cycle as start=1 is accepted, because busy=0 that cycle.
- LOAD_X: x ← table[ptr]; ptr ← ptr+1.
- LOAD_Y: y ← table[ptr]; acc ← (A·x) mod 2^DW, truncated to DW.
- CALC: acc ← (acc + y) mod 2^DW.
- ACC:
  - If acc==C: cnt saturates at 2^CW−1; if cnt was already 2^CW−1, sat ← 1.
  - If ptr was the last word (2^AW−1): go to HOLD; ptr wrap is don't-care.
  - Otherwise ptr ← ptr+1 and go to LOAD_X.
- Scan timing:
  - Each pair takes exactly 4 cycles.
  - HOLD is entered 4·2^(AW-1) edges after the start-sampling edge.
- HOLD:
  - busy=1.
  - While start=1, stay in HOLD; result is unchanged.
  - When start=0 at an edge: result ← cnt, overflow ← sat, done=1 for that one cycle, go to IDLE.
- Back-to-back scans: start reasserted in IDLE begins a new scan; result and overflow hold until the next publish.
- start is ignored in LOAD_X, LOAD_Y, CALC and ACC; a scan cannot be aborted except by reset.
- All arithmetic is unsigned, modulo 2^DW. The counter never wraps.

Test Plan:
- Reset check: assert reset_n=0 mid-operation -> on the same cycle busy=0, done=0, result=0, overflow=0; the next scan of the cleared table with A=3, C=0 gives result=8.
- Legacy table check (DW=8, AW=4):
  - Load words 1,255,0,0,0,2,0,0,0,2,255,5,0,2,0,2; A=3, C=2.
  - Pulse start for 1 cycle -> busy for 32 cycles into HOLD, then done with result=6, overflow=0.
  - 3·255+5 = 770 mod 256 = 2 counts as a match.
- Start handshake: keep start=1 for 50 cycles -> stays in HOLD, result unchanged and no done until start drops; done then fires exactly once.
- Saturation (CW=2): all 8 pairs (0,7) with A=1, C=7 -> result=3, overflow=1. A rerun with C=0 gives result=0, overflow=0.
- Write blocking: write word 0=9 while busy -> table word 0 unchanged; the scan result matches the pre-write expectation; a write after done lands.
- Coefficient capture: change coef_a/coef_c mid-scan -> result reflects the values sampled at start.
